// File: rtl/interrupt_unit.sv
// Interrupt controller: reset sequencing, NMI edge capture, fixed-priority arbitration
// and a request/accept/service handshake with the CPU.
module interrupt_unit #(
    parameter logic [15:0] VEC_BASE = 16'hFFE0,
    parameter int          RST_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] IRQ,
    input  logic        NMI,
    input  logic        GIE,
    input  logic        IF,
    input  logic        Br,
    input  logic        VecDone,
    output logic        rst,
    output logic        INTREQ,
    output logic        INTACK,
    output logic [3:0]  IntIdx,
    output logic [15:0] IntAddr
);

    typedef enum logic [1:0] {
        RSTSEQ  = 2'd0,
        IDLE    = 2'd1,
        REQ     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    localparam logic [3:0] NMI_IDX   = 4'd14;
    localparam logic [3:0] RESET_IDX = 4'd15;
    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

    state_t      state_q, state_d;
    logic        rst_q, rst_d;
    logic        intreq_q, intreq_d;
    logic        intack_q, intack_d;
    logic [3:0]  intidx_q, intidx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        nmi_s_q, nmi_s_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        nmi_rearm_q, nmi_rearm_d;

    logic        nmi_edge;
    logic [14:0] elig;
    logic        any_elig;
    logic [3:0]  win_idx;

    function automatic logic [3:0] highest(input logic [14:0] e);
        logic [3:0] w;
        w = '0;
        for (int i = 0; i < 15; i++) begin
            if (e[i]) w = 4'(i);
        end
        return w;
    endfunction

    always_comb begin
        nmi_edge = NMI & ~nmi_s_q;
        elig     = {nmi_pend_q, IRQ & {14{GIE}}};
        any_elig = |elig;
        win_idx  = highest(elig);

        state_d     = state_q;
        rst_d       = rst_q;
        intreq_d    = intreq_q;
        intack_d    = 1'b0;
        intidx_d    = intidx_q;
        cnt_d       = cnt_q;
        nmi_s_d     = NMI;
        nmi_pend_d  = nmi_pend_q | nmi_edge;
        nmi_rearm_d = nmi_rearm_q;

        case (state_q)
            RSTSEQ: begin
                rst_d    = 1'b1;
                intreq_d = 1'b0;
                intidx_d = RESET_IDX;
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    rst_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IDLE: begin
                if (any_elig) begin
                    intidx_d = win_idx;
                    intreq_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // Acceptance beats both withdrawal and upgrade in the same cycle.
                if (IF | Br) begin
                    intreq_d    = 1'b0;
                    state_d     = SERVICE;
                    nmi_rearm_d = nmi_edge && (intidx_q == NMI_IDX);
                end else if (any_elig) begin
                    intidx_d = win_idx;
                end else begin
                    intreq_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            SERVICE: begin
                if (nmi_edge && (intidx_q == NMI_IDX)) nmi_rearm_d = 1'b1;
                if (VecDone) begin
                    intack_d    = 1'b1;
                    state_d     = IDLE;
                    nmi_rearm_d = 1'b0;
                    // An NMI edge seen while its predecessor was in service stays pending.
                    if (intidx_q == NMI_IDX) nmi_pend_d = nmi_rearm_q | nmi_edge;
                end
            end
            default: begin
                state_d = RSTSEQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RSTSEQ;
            rst_q       <= 1'b1;
            intreq_q    <= 1'b0;
            intack_q    <= 1'b0;
            intidx_q    <= RESET_IDX;
            cnt_q       <= '0;
            nmi_s_q     <= 1'b0;
            nmi_pend_q  <= 1'b0;
            nmi_rearm_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_q       <= rst_d;
            intreq_q    <= intreq_d;
            intack_q    <= intack_d;
            intidx_q    <= intidx_d;
            cnt_q       <= cnt_d;
            nmi_s_q     <= nmi_s_d;
            nmi_pend_q  <= nmi_pend_d;
            nmi_rearm_q <= nmi_rearm_d;
        end
    end

    assign rst     = rst_q;
    assign INTREQ  = intreq_q;
    assign INTACK  = intack_q;
    assign IntIdx  = intidx_q;
    assign IntAddr = VEC_BASE + {11'd0, intidx_q, 1'b0};

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed bench for interrupt_unit: reset release, service handshake, priority,
// withdrawal races, NMI re-arm and reset abort.
module tb_interrupt_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] IRQ;
    logic        NMI, GIE, IF, Br, VecDone;
    logic        rst, INTREQ, INTACK;
    logic [3:0]  IntIdx;
    logic [15:0] IntAddr;

    int passed = 0;
    int total  = 0;

    interrupt_unit #(.VEC_BASE(16'hFFE0), .RST_HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .IRQ(IRQ), .NMI(NMI), .GIE(GIE), .IF(IF),
        .Br(Br), .VecDone(VecDone), .rst(rst), .INTREQ(INTREQ), .INTACK(INTACK),
        .IntIdx(IntIdx), .IntAddr(IntAddr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; IRQ = '0; NMI = 1'b0; GIE = 1'b0; IF = 1'b0; Br = 1'b0; VecDone = 1'b0;

        // Reset release with RST_HOLD=2
        tick(); tick(); tick();
        chk("rst_in_reset", 16'(rst), 16'd1);
        chk("intreq_in_reset", 16'(INTREQ), 16'd0);
        chk("intack_in_reset", 16'(INTACK), 16'd0);
        chk("idx_in_reset", 16'(IntIdx), 16'd15);
        chk("addr_in_reset", IntAddr, 16'hFFFE);
        rst_n = 1'b1;
        tick();
        chk("rst_hold_cycle2", 16'(rst), 16'd1);
        chk("addr_hold", IntAddr, 16'hFFFE);
        chk("intreq_hold", 16'(INTREQ), 16'd0);
        tick();
        chk("rst_released", 16'(rst), 16'd0);
        chk("addr_after_release", IntAddr, 16'hFFFE);

        // Maskable service of IRQ[5]
        GIE = 1'b1; IRQ = 14'h0020;
        tick();
        chk("m_intreq", 16'(INTREQ), 16'd1);
        chk("m_idx", 16'(IntIdx), 16'd5);
        chk("m_addr", IntAddr, 16'hFFEA);
        IF = 1'b1;
        tick();
        chk("m_accept_intreq", 16'(INTREQ), 16'd0);
        IF = 1'b0;
        tick();
        chk("m_no_early_ack", 16'(INTACK), 16'd0);
        VecDone = 1'b1;
        tick();
        chk("m_intack", 16'(INTACK), 16'd1);
        chk("m_ack_idx", 16'(IntIdx), 16'd5);
        VecDone = 1'b0; IRQ = '0;
        tick();
        chk("m_intack_single", 16'(INTACK), 16'd0);
        chk("m_idle_intreq", 16'(INTREQ), 16'd0);

        // Priority upgrade in REQ, frozen after acceptance
        IRQ = 14'h0004;
        tick();
        chk("u_idx2", 16'(IntIdx), 16'd2);
        IRQ = 14'h0204;
        tick();
        chk("u_idx9", 16'(IntIdx), 16'd9);
        chk("u_addr9", IntAddr, 16'hFFF2);
        chk("u_intreq", 16'(INTREQ), 16'd1);
        IF = 1'b1;
        tick();
        chk("u_accept_intreq", 16'(INTREQ), 16'd0);
        IF = 1'b0; IRQ = 14'h1204;
        tick();
        chk("u_frozen", 16'(IntIdx), 16'd9);
        VecDone = 1'b1;
        tick();
        chk("u_intack", 16'(INTACK), 16'd1);
        chk("u_ack_idx", 16'(IntIdx), 16'd9);
        VecDone = 1'b0; IRQ = '0;
        tick();

        // Withdrawal racing Br: acceptance wins
        IRQ = 14'h0008;
        tick();
        chk("w_intreq", 16'(INTREQ), 16'd1);
        GIE = 1'b0; Br = 1'b1;
        tick();
        chk("w_race_intreq", 16'(INTREQ), 16'd0);
        Br = 1'b0;
        tick();
        VecDone = 1'b1;
        tick();
        chk("w_race_intack", 16'(INTACK), 16'd1);
        chk("w_race_idx", 16'(IntIdx), 16'd3);
        VecDone = 1'b0;
        tick();
        // Plain withdrawal returns to IDLE: a later VecDone must not ack
        GIE = 1'b1;
        tick();
        chk("w2_intreq", 16'(INTREQ), 16'd1);
        GIE = 1'b0;
        tick();
        chk("w2_withdrawn", 16'(INTREQ), 16'd0);
        VecDone = 1'b1;
        tick();
        chk("w2_no_intack", 16'(INTACK), 16'd0);
        VecDone = 1'b0; IRQ = '0;
        tick();

        // NMI with GIE=0 beats masked IRQ[13]; second edge in SERVICE re-requests
        IRQ = 14'h2000; NMI = 1'b1;
        tick();
        chk("n_edge_latency", 16'(INTREQ), 16'd0);
        tick();
        chk("n_intreq", 16'(INTREQ), 16'd1);
        chk("n_idx", 16'(IntIdx), 16'd14);
        chk("n_addr", IntAddr, 16'hFFFC);
        IF = 1'b1;
        tick();
        IF = 1'b0; NMI = 1'b0;
        tick();
        NMI = 1'b1;
        tick();
        chk("n_svc_no_intreq", 16'(INTREQ), 16'd0);
        VecDone = 1'b1;
        tick();
        chk("n_intack", 16'(INTACK), 16'd1);
        chk("n_ack_idx", 16'(IntIdx), 16'd14);
        VecDone = 1'b0;
        tick();
        chk("n_reissue_intreq", 16'(INTREQ), 16'd1);
        chk("n_reissue_idx", 16'(IntIdx), 16'd14);
        chk("n_reissue_no_ack", 16'(INTACK), 16'd0);
        Br = 1'b1;
        tick();
        Br = 1'b0; VecDone = 1'b1;
        tick();
        chk("n_second_intack", 16'(INTACK), 16'd1);
        VecDone = 1'b0;
        tick();
        chk("n_pend_cleared", 16'(INTREQ), 16'd0);
        IRQ = '0;
        tick();

        // Reset one cycle before VecDone aborts service and clears nmi_pend
        GIE = 1'b1; IRQ = 14'h0080;
        tick();
        chk("r_intreq", 16'(INTREQ), 16'd1);
        chk("r_idx", 16'(IntIdx), 16'd7);
        IF = 1'b1;
        tick();
        IF = 1'b0; NMI = 1'b0;
        tick();
        NMI = 1'b1;
        tick();
        rst_n = 1'b0; NMI = 1'b0;
        tick();
        chk("r_rst", 16'(rst), 16'd1);
        chk("r_intreq_clr", 16'(INTREQ), 16'd0);
        chk("r_idx15", 16'(IntIdx), 16'd15);
        rst_n = 1'b1; VecDone = 1'b1; IRQ = '0; GIE = 1'b0;
        tick();
        chk("r_no_intack", 16'(INTACK), 16'd0);
        chk("r_rst_hold", 16'(rst), 16'd1);
        VecDone = 1'b0;
        tick();
        chk("r_rst_release", 16'(rst), 16'd0);
        chk("r_no_intack2", 16'(INTACK), 16'd0);
        tick();
        chk("r_nmi_pend_clr", 16'(INTREQ), 16'd0);
        tick();
        chk("r_nmi_pend_clr2", 16'(INTREQ), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/interrupt_unit.md
INTERRUPT_UNIT -- requirements
Module: interrupt_unit

Interface
REQ-001 Parameter VEC_BASE, default 16'hFFE0, SHALL set the base address of the vector table.
REQ-002 Parameter RST_HOLD, default 2, SHALL set the number of cycles rst stays high after rst_n releases (range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 IRQ  input  14  SHALL carry the maskable level requests; bit n is source index n, and index 13 is highest.
REQ-006 NMI  input  1  SHALL be the non-maskable request; it is edge-detected on rising edges.
REQ-007 GIE  input  1  SHALL be the status-register global interrupt enable.
REQ-008 IF  input  1  SHALL be the CPU instruction-fetch (prefetch) strobe.
REQ-009 Br  input  1  SHALL be the CPU branch-detect strobe (PC write-back).
REQ-010 VecDone  input  1  SHALL be a one-cycle CPU strobe; it means the vector has been loaded into PC.
REQ-011 rst  output  1  SHALL be the CPU reset-sequence request.
REQ-012 INTREQ  output  1  SHALL request interrupt entry from the CPU.
REQ-013 INTACK  output  1  SHALL be a one-cycle acknowledge pulse sent to CPU and peripherals.
REQ-014 IntIdx  output  4  SHALL give the index of the source being serviced.
REQ-015 IntAddr  output  16  SHALL equal VEC_BASE + 2*IntIdx at all times.

Function
REQ-016 All outputs SHALL be registered, except IntAddr, which SHALL be derived combinationally from IntIdx.
REQ-017 The state machine SHALL have four states.
- RSTSEQ
- IDLE
- REQ
- SERVICE
REQ-018 RSTSEQ SHALL behave as follows.
- rst=1, IntIdx=15 (IntAddr=16'hFFFE).
- Hold for RST_HOLD cycles after rst_n is sampled high, using an internal counter.
- Then go to IDLE with rst=0.
REQ-019 NMI handling SHALL work as follows.
- Sample NMI each cycle.
- A 0->1 transition SHALL set nmi_pend, which is index 14.
- nmi_pend SHALL clear only on the INTACK cycle for index 14.
- A new edge in that same cycle SHALL re-set nmi_pend; set wins.
REQ-020 Eligibility SHALL be defined as follows.
- Index 14 is eligible when nmi_pend=1, regardless of GIE.
- Index n (0..13) is eligible when IRQ[n]=1 and GIE=1.
- The winner is the highest eligible index.
REQ-021 IDLE: when any source is eligible, the unit SHALL latch the winner into IntIdx, set INTREQ=1 and go to REQ on the next edge.
REQ-022 In REQ, a higher-priority eligible source SHALL replace IntIdx in the following cycle; INTREQ stays 1.
REQ-023 In REQ, when no source remains eligible (IRQ dropped or GIE cleared), the unit SHALL clear INTREQ and return to IDLE.
REQ-024 Acceptance SHALL occur when INTREQ=1 and (IF|Br)=1 in the same cycle.
- Acceptance overrides withdrawal or upgrade in that cycle.
- IntIdx freezes.
- INTREQ=0 next cycle.
- State goes to SERVICE.
REQ-025 SERVICE: on VecDone=1 the unit SHALL pulse INTACK=1 for exactly one cycle, with IntIdx still valid, and then return to IDLE.
REQ-026 The unit SHALL not re-issue INTREQ until the cycle after the INTACK pulse.
REQ-027 In SERVICE, IRQ, GIE and NMI edges SHALL be ignored, except that NMI edges still set nmi_pend.

Reset
REQ-028 While rst_n=0 at a clock edge, the unit SHALL set the following.
- State RSTSEQ, rst=1, INTREQ=0, INTACK=0.
- IntIdx=15, nmi_pend=0, NMI sample register=0.
- Hold counter cleared.
REQ-029 rst_n=0 in any state, including mid-REQ or mid-SERVICE, SHALL abort the transaction; no INTACK is issued for the aborted source.
REQ-030 After reset, the first interrupt SHALL be requestable no earlier than the cycle after rst falls.

Verification
REQ-031 Reset release: rst_n low 3 cycles then high, RST_HOLD=2 -> rst=1 for exactly 2 cycles after release; IntAddr=16'hFFFE throughout; INTREQ=0.
REQ-032 Maskable service: GIE=1, IRQ[5]=1 -> INTREQ=1 with IntIdx=5 and IntAddr=16'hFFEA; IF pulse -> INTREQ=0; VecDone -> single INTACK with IntIdx=5.
REQ-033 Priority upgrade: IRQ[2]=1 in REQ, then IRQ[9]=1 before IF -> IntIdx becomes 9 and IntAddr 16'hFFF2; after IF, IntIdx stays 9 even if IRQ[12] rises.
REQ-034 Withdrawal race: in REQ, GIE drops in the same cycle as Br=1 -> accepted, SERVICE entered; if GIE drops with no IF/Br -> INTREQ=0 and IDLE.
REQ-035 NMI: GIE=0, NMI 0->1 while IRQ[13]=1 -> IntIdx=14 and IntAddr=16'hFFFC; a second NMI edge during SERVICE -> a new INTREQ for 14 after the INTACK.
REQ-036 Reset mid-SERVICE: rst_n=0 one cycle before VecDone -> no INTACK; rst=1; nmi_pend=0.
